// File: rtl/dnn_seq_pkg.sv
// Shared types for the DNN layer sequencer: descriptor layout, FSM states, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dnn_seq_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LEN_W_DEF  = 26;

  // Packed LSB->MSB: px_addr, px_len, wt_addr, wt_len, out_addr, out_len, last_layer.
  // The first member listed lands in the MSBs.
  typedef struct packed {
    logic                  last_layer;
    logic [LEN_W_DEF-1:0]  out_len;
    logic [ADDR_W_DEF-1:0] out_addr;
    logic [LEN_W_DEF-1:0]  wt_len;
    logic [ADDR_W_DEF-1:0] wt_addr;
    logic [LEN_W_DEF-1:0]  px_len;
    logic [ADDR_W_DEF-1:0] px_addr;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RUN    = 2'd2,
    ST_RETIRE = 2'd3
  } state_e;

endpackage

// File: rtl/dnn_seq_cmd_port.sv
// One DMA command channel: loads addr/len, holds valid until accepted, remembers acceptance.
// Latency: valid registered one cycle after load; done is combinational on the accepting beat.
// Backpressure: valid and addr/len are held stable while ready is low.
// Ports: clk/rst (sync active-high), load + load_addr/load_len from the sequencer,
//        cmd_valid/cmd_ready/cmd_addr/cmd_len to the DMA, done = accepted this layer.
module dnn_seq_cmd_port
  import dnn_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              done
);

  logic accepted;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      accepted  <= 1'b0;
    end else if (load) begin
      cmd_valid <= 1'b1;
      cmd_addr  <= load_addr;
      cmd_len   <= load_len;
      accepted  <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
      accepted  <= 1'b1;
    end
  end

  // Includes the accepting beat itself so the FSM can leave ISSUE on that same edge.
  assign done = accepted | (cmd_valid & cmd_ready);

endmodule

// File: rtl/dnn_layer_sequencer.sv
// Layer scheduler: takes descriptors, issues px/wt/out DMA commands, retires on all three tlasts.
// Latency: desc accept N -> cmds N+2; last tlast M -> layer_done M+1, next cmds M+2.
// Backpressure: s_desc_ready low while the one-deep shadow is full; cmd valid held until ready.
// Ports: aclk/areset (sync active-high), s_desc_* descriptor in, m_{px,wt,out}_cmd_* DMA
//        commands, mon_*_last stream completion, busy/layer_done/net_done/layer_cnt/timeout status.
// Optional macro DNN_SEQ_TIMEOUT_EN adds a 32-bit stall watchdog driving a sticky timeout.
module dnn_layer_sequencer
  import dnn_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DESC_W = 3*ADDR_W + 3*LEN_W + 1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_desc_valid,
  output logic              s_desc_ready,
  input  logic [DESC_W-1:0] s_desc_data,
  output logic              m_px_cmd_valid,
  input  logic              m_px_cmd_ready,
  output logic [ADDR_W-1:0] m_px_cmd_addr,
  output logic [LEN_W-1:0]  m_px_cmd_len,
  output logic              m_wt_cmd_valid,
  input  logic              m_wt_cmd_ready,
  output logic [ADDR_W-1:0] m_wt_cmd_addr,
  output logic [LEN_W-1:0]  m_wt_cmd_len,
  output logic              m_out_cmd_valid,
  input  logic              m_out_cmd_ready,
  output logic [ADDR_W-1:0] m_out_cmd_addr,
  output logic [LEN_W-1:0]  m_out_cmd_len,
  input  logic              mon_px_last,
  input  logic              mon_wt_last,
  input  logic              mon_out_last,
  output logic              busy,
  output logic              layer_done,
  output logic              net_done,
  output logic [15:0]       layer_cnt,
  output logic              timeout
);

  localparam int PX_LEN_LSB   = ADDR_W;
  localparam int WT_ADDR_LSB  = ADDR_W + LEN_W;
  localparam int WT_LEN_LSB   = 2*ADDR_W + LEN_W;
  localparam int OUT_ADDR_LSB = 2*ADDR_W + 2*LEN_W;
  localparam int OUT_LEN_LSB  = 3*ADDR_W + 2*LEN_W;
  localparam int LAST_BIT     = 3*ADDR_W + 3*LEN_W;

  state_e            state, state_d;
  logic              shadow_valid, shadow_valid_d;
  logic [DESC_W-1:0] shadow;
  logic              active_last;
  logic [2:0]        flags;        // {out, wt, px} completion seen this layer
  logic [2:0]        mon;
  logic              desc_fire;
  logic              load_active;
  logic              retire_go;
  logic              px_done, wt_done, out_done;

  assign mon       = {mon_out_last, mon_wt_last, mon_px_last};
  assign desc_fire = s_desc_valid & s_desc_ready;
  // Pulses landing on the deciding cycle count, so layer_done follows the last tlast by one cycle.
  assign retire_go = (state == ST_RUN) && (&(flags | mon));

  always_comb begin
    state_d     = state;
    load_active = 1'b0;
    case (state)
      ST_IDLE: begin
        if (shadow_valid) begin
          load_active = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (px_done && wt_done && out_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (retire_go) state_d = ST_RETIRE;
      end
      ST_RETIRE: begin
        if (shadow_valid) begin
          load_active = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new descriptor arriving on the drain cycle refills the shadow with no bubble.
    if (desc_fire) shadow_valid_d = 1'b1;
    else if (load_active) shadow_valid_d = 1'b0;
    else shadow_valid_d = shadow_valid;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= ST_IDLE;
      shadow_valid <= 1'b0;
      shadow       <= '0;
      active_last  <= 1'b0;
      flags        <= '0;
      s_desc_ready <= 1'b1;
      busy         <= 1'b0;
      layer_done   <= 1'b0;
      net_done     <= 1'b0;
      layer_cnt    <= '0;
    end else begin
      state        <= state_d;
      shadow_valid <= shadow_valid_d;
      s_desc_ready <= ~shadow_valid_d;
      busy         <= (state_d != ST_IDLE) | shadow_valid_d;
      if (desc_fire) shadow <= s_desc_data;
      if (load_active) active_last <= shadow[LAST_BIT];
      if (state == ST_RETIRE) flags <= '0;
      else if (state == ST_ISSUE || state == ST_RUN) flags <= flags | mon;
      layer_done <= retire_go;
      net_done   <= retire_go & active_last;
      if (retire_go) layer_cnt <= active_last ? 16'd0 : layer_cnt + 16'd1;
    end
  end

  dnn_seq_cmd_port #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_px_cmd (
    .clk(aclk), .rst(areset), .load(load_active),
    .load_addr(shadow[0 +: ADDR_W]), .load_len(shadow[PX_LEN_LSB +: LEN_W]),
    .cmd_ready(m_px_cmd_ready), .cmd_valid(m_px_cmd_valid),
    .cmd_addr(m_px_cmd_addr), .cmd_len(m_px_cmd_len), .done(px_done)
  );

  dnn_seq_cmd_port #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wt_cmd (
    .clk(aclk), .rst(areset), .load(load_active),
    .load_addr(shadow[WT_ADDR_LSB +: ADDR_W]), .load_len(shadow[WT_LEN_LSB +: LEN_W]),
    .cmd_ready(m_wt_cmd_ready), .cmd_valid(m_wt_cmd_valid),
    .cmd_addr(m_wt_cmd_addr), .cmd_len(m_wt_cmd_len), .done(wt_done)
  );

  dnn_seq_cmd_port #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_out_cmd (
    .clk(aclk), .rst(areset), .load(load_active),
    .load_addr(shadow[OUT_ADDR_LSB +: ADDR_W]), .load_len(shadow[OUT_LEN_LSB +: LEN_W]),
    .cmd_ready(m_out_cmd_ready), .cmd_valid(m_out_cmd_valid),
    .cmd_addr(m_out_cmd_addr), .cmd_len(m_out_cmd_len), .done(out_done)
  );

`ifdef DNN_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timeout_q;
  logic        activity;

  assign activity = desc_fire | (|mon)
                  | (m_px_cmd_valid & m_px_cmd_ready)
                  | (m_wt_cmd_valid & m_wt_cmd_ready)
                  | (m_out_cmd_valid & m_out_cmd_ready);

  // Only a stall while work is in flight counts; the counter saturates and the flag sticks.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == ST_ISSUE || state == ST_RUN) && !activity) begin
        if (wd_cnt != 32'hFFFF_FFFF) wd_cnt <= wd_cnt + 32'd1;
      end else begin
        wd_cnt <= '0;
      end
      if (wd_cnt == 32'hFFFF_FFFF) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/dnn_layer_sequencer.md
# dnn_layer_sequencer

Layer-level scheduler for the DNN engine. Accepts per-layer descriptors and issues one read command each to the pixel and weight MM2S DMA channels and one write command to the output S2MM channel. It then tracks stream completion (pixel `tlast`, weight `tlast`, engine output `tlast`) and retires the layer. A one-deep shadow register lets the next layer's descriptor be accepted while the current layer runs, so commands issue back-to-back.

## Interface
Parameters:
- `ADDR_W`, 32, DMA address width.
- `LEN_W`, 26, DMA byte-length width.
- `DESC_W`, 3*ADDR_W+3*LEN_W+1, descriptor width. Layout LSB→MSB: px_addr, px_len, wt_addr, wt_len, out_addr, out_len, last_layer.

Ports:
- `aclk` in 1: sole clock.
- `areset` in 1: reset, synchronous, active-high.
- `s_desc_valid`/`s_desc_ready` in/out 1: descriptor handshake.
- `s_desc_data` in DESC_W: descriptor.
- `m_px_cmd_valid`/`m_px_cmd_ready` out/in 1: pixel DMA command handshake.
- `m_px_cmd_addr`, `m_px_cmd_len` out ADDR_W/LEN_W: pixel DMA command.
- `m_wt_cmd_*`: same for the weight channel.
- `m_out_cmd_*`: same for the output channel.
- `mon_px_last` in 1: pixel stream `tvalid&tready&tlast` into the engine.
- `mon_wt_last` in 1: weight stream beat with `tlast`.
- `mon_out_last` in 1: engine output `m_axis_tvalid&tready&tlast`.
- `busy` out 1: a layer is active or pending.
- `layer_done` out 1: one-cycle pulse per retired layer.
- `net_done` out 1: one-cycle pulse when a layer with last_layer=1 retires.
- `layer_cnt` out 16: retired layers since `net_done` or reset; wraps at 2^16.
- `timeout` out 1: sticky watchdog flag (only with the macro; tied 0 otherwise).

## Operation
- FSM states: IDLE, ISSUE, RUN, RETIRE.
- IDLE: when the shadow register is valid, move it into the active register and go to ISSUE.
- ISSUE: assert all three `cmd_valid`s together.
  - Each deasserts independently after its own `valid&ready`.
  - Go to RUN when all three are accepted; a command may complete in the same cycle it is asserted.
- RUN: three sticky completion flags, px, wt and out, set by the `mon_*_last` pulses.
  - Pulses arriving during ISSUE are also captured.
  - Go to RETIRE when all three flags are set.
- RETIRE, single cycle:
  - Pulse `layer_done` and increment `layer_cnt`.
  - If last_layer, also pulse `net_done` and clear `layer_cnt` to 0.
  - Clear the flags.
  - Go to ISSUE if the shadow register is valid (loading it into active), else IDLE.
- Shadow register: `s_desc_ready` = !shadow_valid.
  - If shadow is loaded into active in the same cycle a new descriptor handshakes, the new descriptor lands in shadow; no bubble.
- A `mon_*_last` pulse with its flag already set is ignored; no counting across layers.
- `busy` = (state != IDLE) | shadow_valid.
- Zero-length fields are passed to the DMA unchanged; no special handling.
- `areset` mid-operation returns to IDLE, drops the shadow and pending commands, and clears the flags. No DMA commands are outstanding after release.

## Timing
- Reset values: all `cmd_valid` 0, `cmd_addr`/`cmd_len` 0, `s_desc_ready` 1, `busy` 0, `layer_done` 0, `net_done` 0, `layer_cnt` 0, `timeout` 0.
- Descriptor accepted in IDLE at cycle N: `cmd_valid`s high at N+2 (N+1 shadow load, then IDLE→ISSUE).
- Last completion pulse at cycle M: `layer_done` at M+1. With shadow valid, next `cmd_valid`s at M+2.
- `cmd_addr`/`cmd_len` stay stable while `cmd_valid` is high (AXI-Stream rule). Valid never drops without ready.
- All outputs are registered.

## Configuration
- `DNN_SEQ_TIMEOUT_EN` defined: adds a 32-bit watchdog.
  - Counts cycles in ISSUE or RUN with no handshake and no `mon_*_last`; resets on any such event.
  - At `32'hFFFF_FFFF` it sets `timeout`, which is sticky until `areset`. FSM behaviour is unchanged.
- Undefined: no counter; `timeout` is a constant 0.

## Structure
- Package `dnn_seq_pkg`:
  - `desc_t` packed struct (field order as `DESC_W` layout).
  - `state_e` enum.
  - Default `ADDR_W`/`LEN_W`.
- Sub-module `dnn_seq_cmd_port`: one command channel's valid/hold/accepted logic, instantiated three times.

## Test plan
- Single layer (px 0x1000/256, wt 0x2000/64, out 0x3000/128, last=1), DMA ready always 1, pulses px@+10, wt@+12, out@+40 → three commands at N+2 with exact addr/len; `layer_done` and `net_done` one cycle after out pulse; `layer_cnt` ends 0.
- Two back-to-back descriptors, second presented during RUN → `s_desc_ready` drops after second accept; second commands at M+2 after first retire; `layer_cnt`=1 then 0 on `net_done`.
- Weight `cmd_ready` held 0 for 20 cycles, others 1 → px/out valid drop after 1 cycle; wt valid stays high with stable addr; RUN entered only after wt accept.
- Out `tlast` pulse arriving during ISSUE, before px accept → captured; layer retires without another pulse.
- `areset` asserted in RUN with shadow full → next cycle all outputs at reset values, `busy`=0. A fresh descriptor then runs normally.
- With `DNN_SEQ_TIMEOUT_EN` and counter forced near max via short-sim override → `timeout` sets and stays set; FSM still retires after pulses.
